// File: rtl/modulo_varredura_canais_pkg.sv
// Shared types and constants for the 16-channel demux scan sequencer.
package modulo_varredura_canais_pkg;

  localparam int NUM_CANAIS = 16;
  localparam int SEL_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } estado_t;

endpackage

// File: rtl/modulo_prox_canal.sv
// Combinational search for the next enabled channel strictly above the current
// one, wrapping modulo 16; also flags a wrap and an empty mask.
module modulo_prox_canal
  import modulo_varredura_canais_pkg::*;
(
  input  logic [SEL_W-1:0]      atual,
  input  logic [NUM_CANAIS-1:0] mask,
  output logic [SEL_W-1:0]      prox,
  output logic                  wrap,
  output logic                  nenhum
);

  // Walk the distances from farthest to nearest so the nearest enabled one wins;
  // distance 16 lands back on the current channel (single-channel case).
  always_comb begin
    // NOTE: prox gets a default before the loop so no path leaves it unassigned (no latch).
    prox = atual;
    for (int i = NUM_CANAIS; i > 0; i--) begin
      if (mask[atual + SEL_W'(i)]) prox = atual + SEL_W'(i);
    end
  end

  assign wrap   = (prox <= atual);
  assign nenhum = (mask == '0);

endmodule

// File: rtl/modulo_varredura_canais.sv
// Round-robin scan sequencer driving S/E of a 1-to-16 demux; S only moves while E is low.
// Optional per-channel masking is enabled by defining SCAN_MASK_EN.
module modulo_varredura_canais
  import modulo_varredura_canais_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 1000,
  parameter int unsigned BLANK_CYC = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RUN,
  input  logic [NUM_CANAIS-1:0] MASK,
  output logic [SEL_W-1:0]      S,
  output logic                  E,
  output logic                  FRAME,
  output logic                  BUSY
);

  localparam logic [CNT_W-1:0] BLANK_FIM = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_FIM = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] UM        = CNT_W'(1);

  estado_t               state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;   // next channel still to be picked in this BLANK
  logic [SEL_W-1:0]      s_d;
  logic                  e_d, frame_d, busy_d;
  logic [NUM_CANAIS-1:0] mask_ef;
  logic [SEL_W-1:0]      busca_atual, prox;
  logic                  wrap, nenhum;

`ifdef SCAN_MASK_EN
  assign mask_ef = MASK;
`else
  // MASK is overridden so that every channel is always scanned.
  assign mask_ef = MASK | {NUM_CANAIS{1'b1}};
`endif

  // From IDLE, searching "above 15" yields the lowest enabled channel.
  assign busca_atual = (state_q == ST_IDLE) ? {SEL_W{1'b1}} : S;

  modulo_prox_canal u_prox (
    .atual  (busca_atual),
    .mask   (mask_ef),
    .prox   (prox),
    .wrap   (wrap),
    .nenhum (nenhum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    s_d     = S;
    frame_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_d = '0;
        if (RUN && !nenhum) begin
          s_d     = prox;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (nenhum) begin
            s_d     = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            s_d     = prox;
            frame_d = wrap;
            cnt_d   = cnt_q + UM;
          end
        end else if (cnt_q == BLANK_FIM) begin
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt_q + UM;
        end
      end
      ST_DRIVE: begin
        // The dwell always runs to completion; RUN is only looked at here.
        if (cnt_q == DWELL_FIM) begin
          cnt_d = '0;
          if (RUN) begin
            pend_d  = 1'b1;
            state_d = ST_BLANK;
          end else begin
            s_d     = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + UM;
        end
      end
      default: begin
        s_d     = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    e_d    = (state_d == ST_DRIVE);
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: the reset clears only control/output flops; there is no storage array to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      S       <= '0;
      E       <= 1'b0;
      FRAME   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      S       <= s_d;
      E       <= e_d;
      FRAME   <= frame_d;
      BUSY    <= busy_d;
    end
  end

endmodule

// File: tb/tb_modulo_varredura_canais.sv
// Scoreboard bench: stimulus pushes expected channel/frame per dwell, a monitor checks each dwell.
module tb_modulo_varredura_canais;

  localparam int D = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RUN = 1'b0;
  logic [15:0] MASK = 16'h0000;
  logic [3:0]  S;
  logic        E, FRAME, BUSY;

  typedef struct {
    int ch;
    int frame;
  } exp_t;

  exp_t sb_q[$];
  int   rise_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   dwell_count = 0;
  int   cyc = 0;
  bit   sb_on = 1'b1;

  modulo_varredura_canais #(
    .DWELL_CYC (D),
    .BLANK_CYC (B),
    .CNT_W     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RUN   (RUN),
    .MASK  (MASK),
    .S     (S),
    .E     (E),
    .FRAME (FRAME),
    .BUSY  (BUSY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: channel-order rules expressed over the effective mask.
  function automatic logic [15:0] eff(input logic [15:0] m);
`ifdef SCAN_MASK_EN
    return m;
`else
    return 16'hFFFF;
`endif
  endfunction

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_above(input int cur, input logic [15:0] m);
    for (int k = 1; k <= 16; k++) if (m[(cur + k) % 16]) return (cur + k) % 16;
    return cur;
  endfunction

  // Monitor: one scoreboard pop per E rise; dwell/gap lengths and S stability per dwell.
  initial begin
    bit e_prev = 1'b0;
    bit gap_valid = 1'b0;
    bit s_ok = 1'b1;
    logic [3:0] s_prev = '0;
    int hi_len = 0;
    int low_len = 0;
    int frame_seen = 0;
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_prev = 1'b0; gap_valid = 1'b0; hi_len = 0; frame_seen = 0;
      end else begin
        if (FRAME) frame_seen++;
        if (!BUSY) begin
          gap_valid = 1'b0;
          frame_seen = 0;
        end
        if (E && !e_prev) begin
          dwell_count++;
          rise_cyc.push_back(cyc);
          if (sb_on) begin
            if (sb_q.size() == 0) begin
              check("sb_unexpected_dwell", 1, 0);
            end else begin
              x = sb_q.pop_front();
              check("dwell_sel", S, x.ch);
              check("frame_before_dwell", frame_seen, x.frame);
            end
          end
          if (gap_valid) check("blank_gap", low_len, B);
          frame_seen = 0;
          hi_len = 1;
          s_ok = 1'b1;
        end else if (E && e_prev) begin
          hi_len++;
          if (S != s_prev) s_ok = 1'b0;
        end else if (!E && e_prev) begin
          check("dwell_len", hi_len, D);
          check("s_stable_in_dwell", s_ok, 1);
          low_len = 1;
          gap_valid = BUSY;
        end else begin
          low_len++;
        end
        e_prev = E;
        s_prev = S;
      end
    end
  end

  task automatic wait_dwells(input int target, input string name);
    int t = 0;
    while (dwell_count < target && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    check({name, "_dwell_timeout"}, dwell_count >= target, 1);
  endtask

  task automatic stop_and_idle(input string name);
    int t = 0;
    @(negedge clk); #1;
    RUN = 1'b0;
    while (BUSY && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    check({name, "_idle_busy"}, BUSY, 0);
    check({name, "_idle_s"}, S, 0);
    check({name, "_idle_e"}, E, 0);
  endtask

  // Runs n dwells from IDLE; RUN is dropped in cycle 2 of the last dwell.
  task automatic run_scan(input logic [15:0] m0, input int n, input bit rnd, input string name);
    int cur, nxt, base;
    logic [15:0] mm;
    @(negedge clk); #1;
    base = dwell_count;
    MASK = m0;
    cur = lowest(eff(m0));
    sb_q.push_back('{cur, 0});
    RUN = 1'b1;
    for (int k = 1; k < n; k++) begin
      wait_dwells(base + k, name);
      if (rnd && $urandom_range(0, 1) == 1) begin
        mm = 16'($urandom);
        if (mm == 16'h0000) mm = 16'h0001;
        MASK = mm;
      end
      nxt = next_above(cur, eff(MASK));
      sb_q.push_back('{nxt, (nxt <= cur) ? 1 : 0});
      cur = nxt;
    end
    wait_dwells(base + n, name);
    stop_and_idle(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, n, t, lo;
    logic [15:0] m;

    #2;
    check("reset_s", S, 0);
    check("reset_e", E, 0);
    check("reset_frame", FRAME, 0);
    check("reset_busy", BUSY, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full scan 0..15,0 with frame length check.
    b = dwell_count;
    n = $countones(eff(16'hFFFF));
    run_scan(16'hFFFF, n + 1, 1'b0, "full");
    check("full_frame_len", rise_cyc[b + n] - rise_cyc[b], n * (D + B));

    // Sparse mask.
    b = dwell_count;
    n = $countones(eff(16'h8101));
    run_scan(16'h8101, n + 1, 1'b0, "sparse");
    check("sparse_frame_len", rise_cyc[b + n] - rise_cyc[b], n * (D + B));

    // Stop in the middle of channel 5's dwell.
    run_scan(16'hFFFF, 6, 1'b0, "stop_ch5");

    // Single channel and the one-bit mask case.
    run_scan(16'h0040, 3, 1'b0, "single");
    run_scan(16'h0001, 17, 1'b0, "mask0001");

    // Random masks, changing between selections.
    for (int it = 0; it < 6; it++) begin
      m = 16'($urandom);
      if (m == 16'h0000) m = 16'h0100;
      run_scan(m, $urandom_range(2, 8), 1'b1, "rand");
    end

    // Reset in the middle of a dwell, then restart.
    @(negedge clk); #1;
    MASK = 16'h0FF0;
    lo = lowest(eff(16'h0FF0));
    b = dwell_count;
    sb_q.push_back('{lo, 0});
    RUN = 1'b1;
    wait_dwells(b + 1, "rst_mid");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_e", E, 0);
    check("rst_mid_s", S, 0);
    check("rst_mid_frame", FRAME, 0);
    check("rst_mid_busy", BUSY, 0);
    sb_q.push_back('{lo, 0});
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_dwells(b + 2, "rst_restart");
    stop_and_idle("rst_restart");

    // Empty mask, then a single channel appears.
    @(negedge clk); #1;
    sb_on = 1'b0;
    MASK = 16'h0000;
    RUN = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("empty_busy", BUSY, (eff(16'h0000) != 16'h0000) ? 1 : 0);
    RUN = 1'b0;
    t = 0;
    while (BUSY && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    check("empty_back_idle", BUSY, 0);
    sb_on = 1'b1;
    @(negedge clk); #1;
    MASK = 16'h0010;
    lo = lowest(eff(16'h0010));
    sb_q.push_back('{lo, 0});
    RUN = 1'b1;
    @(posedge clk); #1;
    check("empty_then_sel", S, lo);
    n = 0;
    while (!E && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("empty_then_e_delay", n, B);
    stop_and_idle("empty_then");

    repeat (5) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
